// File: rtl/ram_stream_reader.sv
// -----------------------------------------------------------------------------
// ram_stream_reader
//
// Read-side master for a simple dual-port RAM. On a start command it reads
// `length` consecutive words beginning at `base_addr` and presents them, in
// address order, on a valid/ready stream. The RAM read port has no enable, so
// every issued read returns data READ_LATENCY cycles later whether or not the
// consumer is ready. A credit rule bounds reads in flight plus words buffered to
// the skid FIFO depth, so no returning word is ever dropped.
//
// Ports
//   clk        clock, all state on posedge
//   rst        asynchronous reset, active-high
//   start      one-cycle command strobe, accepted only in IDLE
//   base_addr  first RAM word address of the run
//   length     number of words to read (0 allowed, 2**ADDR_WIDTH max)
//   busy       high while the command is reading or draining
//   done       one-cycle pulse once the final word has been handshaken
//   ram_raddr  RAM read address
//   ram_rdata  RAM read data, valid READ_LATENCY cycles after the address
//   m_valid    output word valid
//   m_ready    downstream accept
//   m_data     output word (zero while m_valid is low)
//   m_last     marks the final word of the run
// -----------------------------------------------------------------------------
module ram_stream_reader #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 64,
  parameter int READ_LATENCY = 0,
  parameter int LEN_WIDTH    = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  // Enough entries to cover every word that can be in the RAM pipe plus the
  // one sitting on the output, which sustains one word per cycle.
  localparam int FIFO_DEPTH = READ_LATENCY + 2;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W      = CNT_W + 1;

  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [SUM_W-1:0] CREDITS = SUM_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
  logic [LEN_WIDTH-1:0]    rem_q, rem_d;
  logic [CNT_W-1:0]        inflight_q, inflight_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0]   fifo_data_q [FIFO_DEPTH];
  logic                    fifo_last_q [FIFO_DEPTH];

  logic credit_ok;
  logic issue;
  logic issue_last;
  logic ret;
  logic ret_last;
  logic push;
  logic pop;

  // Circular pointer advance; depth is not necessarily a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  // Credit check uses registered state only: reads still in the RAM pipe
  // plus words already buffered must leave room for one more.
  assign credit_ok = ({1'b0, inflight_q} + {1'b0, cnt_q}) < CREDITS;

  // ---------------------------------------------------------------------------
  // Command FSM and read issue
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    raddr_d    = raddr_q;
    rem_d      = rem_q;
    issue      = 1'b0;
    issue_last = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length == '0) begin
            // Empty run: no reads, address untouched, completion next cycle.
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            raddr_d = base_addr;
            rem_d   = length;
          end
        end
      end
      S_RUN: begin
        if (credit_ok) begin
          issue   = 1'b1;
          raddr_d = raddr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          if (rem_q == LEN_WIDTH'(1)) begin
            issue_last = 1'b1;
            state_d    = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (pop && m_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      raddr_q <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      rem_q   <= rem_d;
    end
  end

  assign ram_raddr = raddr_q;
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);

  // ---------------------------------------------------------------------------
  // Return tracking: a valid/last marker travels alongside each read through
  // the RAM latency so the FIFO knows exactly when rdata is meaningful.
  // ---------------------------------------------------------------------------
  generate
    if (READ_LATENCY == 0) begin : g_comb_ret
      assign ret      = issue;
      assign ret_last = issue_last;
    end else begin : g_pipe_ret
      logic [READ_LATENCY-1:0] vld_q, vld_d;
      logic [READ_LATENCY-1:0] last_q, last_d;

      always_comb begin
        vld_d     = vld_q << 1;
        last_d    = last_q << 1;
        vld_d[0]  = issue;
        last_d[0] = issue_last;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q  <= '0;
          last_q <= '0;
        end else begin
          vld_q  <= vld_d;
          last_q <= last_d;
        end
      end

      assign ret      = vld_q[READ_LATENCY-1];
      assign ret_last = last_q[READ_LATENCY-1];
    end
  endgenerate

  assign inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(ret);

  // ---------------------------------------------------------------------------
  // Skid FIFO: returning words are captured unconditionally; the head entry
  // drives the stream directly from registered storage.
  // ---------------------------------------------------------------------------
  assign push     = ret;
  assign pop      = m_valid && m_ready;
  assign cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
  assign wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
  assign rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= ram_rdata;
      fifo_last_q[wr_ptr_q] <= ret_last;
    end
  end

  // Storage is not reset, so the head is masked until it holds a real word.
  assign m_valid = (cnt_q != '0);
  assign m_data  = m_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign m_last  = m_valid && fifo_last_q[rd_ptr_q];

endmodule
